agg_row_buffer: RTL and testbench

- Upstream stage of the transpose buffer.
- Accepts one DATA_WIDTH word per cycle from the memory read path and packs FETCH_WIDTH consecutive words into a row.
- Presents each completed row as the transpose buffer's fetch-width input word.
- Double-banked: one bank fills while the other drains, so a word stream of up to one word per cycle is sustained.

---
 rtl/agg_row_pkg.sv | 13 +
 rtl/agg_row_bank.sv | 100 ++++++++++
 rtl/agg_row_buffer.sv | 119 +++++++++++
 tb/tb_agg_row_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/agg_row_pkg.sv
// Shared types and default widths for the row aggregation buffer.
package agg_row_pkg;

    localparam int unsigned AGG_DATA_WIDTH  = 1;
    localparam int unsigned AGG_FETCH_WIDTH = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/agg_row_bank.sv
// One row bank: slot storage (not reset), fill state and per-slot write enables.
// Optional flush support (zero-fill and partial flag) under AGG_ROW_FLUSH_EN.
module agg_row_bank import agg_row_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = AGG_DATA_WIDTH,
    parameter int unsigned FETCH_WIDTH = AGG_FETCH_WIDTH,
    localparam int unsigned IDX_W      = $clog2(FETCH_WIDTH),
    localparam int unsigned ROW_W      = FETCH_WIDTH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  complete,
    input  logic                  rd_done,
`ifdef AGG_ROW_FLUSH_EN
    input  logic                  zero_fill,
    input  logic                  mark_partial,
    output logic                  partial,
`endif
    output bank_state_e           state,
    output logic [ROW_W-1:0]      row
);

    bank_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] slot_q [FETCH_WIDTH];
    logic [DATA_WIDTH-1:0] slot_d [FETCH_WIDTH];

    // Read drains a FULL bank; writes only target a non-FULL bank, so they never collide.
    always_comb begin
        state_d = state_q;
        if (rd_done) begin
            state_d = EMPTY;
        end else if (complete) begin
            state_d = FULL;
        end else if (wr_en) begin
            state_d = FILLING;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            slot_d[i] = slot_q[i];
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                slot_d[i] = wr_data;
            end
`ifdef AGG_ROW_FLUSH_EN
            // Flush clears every slot past the last one written this row.
            else if (zero_fill && ((IDX_W'(i) > wr_idx) || (!wr_en && (IDX_W'(i) == wr_idx)))) begin
                slot_d[i] = '0;
            end
`endif
        end
    end

    always_comb begin
        row = '0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            row[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

`ifdef AGG_ROW_FLUSH_EN
    logic partial_q, partial_d;

    always_comb begin
        partial_d = partial_q;
        if (complete) begin
            partial_d = mark_partial;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_q <= 1'b0;
        end else begin
            partial_q <= partial_d;
        end
    end

    assign partial = partial_q;
`endif

    assign state = state_q;

endmodule

// File: rtl/agg_row_buffer.sv
// Double-banked word-to-row packer feeding the transpose buffer.
// Define AGG_ROW_FLUSH_EN to add the flush input and out_partial output.
module agg_row_buffer import agg_row_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = AGG_DATA_WIDTH,
    parameter int unsigned FETCH_WIDTH = AGG_FETCH_WIDTH,
    parameter int unsigned NUM_BANKS   = 2,
    localparam int unsigned IDX_W      = $clog2(FETCH_WIDTH),
    localparam int unsigned ROW_W      = FETCH_WIDTH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ROW_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef AGG_ROW_FLUSH_EN
    input  logic                  flush,
    output logic                  out_partial,
`endif
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic [IDX_W-1:0]      word_idx,
    output logic [15:0]           row_count
);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [15:0]      row_count_q, row_count_d;

    bank_state_e      bank_state [NUM_BANKS];
    logic [ROW_W-1:0] bank_row   [NUM_BANKS];

    logic wr_fire, wr_last, flush_fire, complete, rd_fire;

    assign in_ready  = (bank_state[wr_bank_q] != FULL);
    assign out_valid = (bank_state[rd_bank_q] == FULL);
    assign out_data  = out_valid ? bank_row[rd_bank_q] : '0;

    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_fire && (word_idx_q == IDX_W'(FETCH_WIDTH - 1));
    assign rd_fire  = out_valid && out_ready;
`ifdef AGG_ROW_FLUSH_EN
    assign flush_fire = flush && in_ready && (word_idx_q != '0);
`else
    assign flush_fire = 1'b0;
`endif
    assign complete = wr_last || flush_fire;

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        word_idx_d  = word_idx_q;
        row_count_d = row_count_q;
        if (complete) begin
            word_idx_d = '0;
            wr_bank_d  = ~wr_bank_q;
        end else if (wr_fire) begin
            word_idx_d = word_idx_q + IDX_W'(1);
        end
        if (rd_fire) begin
            rd_bank_d   = ~rd_bank_q;
            row_count_d = row_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            word_idx_q  <= '0;
            row_count_q <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            word_idx_q  <= word_idx_d;
            row_count_q <= row_count_d;
        end
    end

`ifdef AGG_ROW_FLUSH_EN
    logic bank_partial [NUM_BANKS];
    assign out_partial = out_valid && bank_partial[rd_bank_q];
`endif

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        logic sel_wr, sel_rd;
        assign sel_wr = (wr_bank_q == 1'(b));
        assign sel_rd = (rd_bank_q == 1'(b));

        agg_row_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FETCH_WIDTH (FETCH_WIDTH)
        ) u_bank (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_en        (wr_fire && sel_wr),
            .wr_idx       (word_idx_q),
            .wr_data      (in_data),
            .complete     (complete && sel_wr),
            .rd_done      (rd_fire && sel_rd),
`ifdef AGG_ROW_FLUSH_EN
            .zero_fill    (flush_fire && sel_wr),
            .mark_partial (flush_fire && !wr_last),
            .partial      (bank_partial[b]),
`endif
            .state        (bank_state[b]),
            .row          (bank_row[b])
        );
    end

    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign word_idx  = word_idx_q;
    assign row_count = row_count_q;

endmodule

// File: tb/tb_agg_row_buffer.sv
// Directed and randomized self-checking bench for agg_row_buffer.
module tb_agg_row_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_data;
    logic        in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        wr_bank;
    logic        rd_bank;
    logic [1:0]  word_idx;
    logic [15:0] row_count;
`ifdef AGG_ROW_FLUSH_EN
    logic        flush;
    logic        out_partial;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    agg_row_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef AGG_ROW_FLUSH_EN
        .flush       (flush),
        .out_partial (out_partial),
`endif
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .word_idx    (word_idx),
        .row_count   (row_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 1'b0;
        out_ready = 1'b0;
`ifdef AGG_ROW_FLUSH_EN
        flush     = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [3:0] exp_q [$];
    logic [3:0] acc;
    logic [3:0] exp_row;
    int         slot;
    int         sent;
    int         accepted;

    initial begin
        do_reset();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_wr_bank",   32'(wr_bank),   32'd0);
        check_eq("rst_rd_bank",   32'(rd_bank),   32'd0);
        check_eq("rst_word_idx",  32'(word_idx),  32'd0);
        check_eq("rst_row_count", 32'(row_count), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);

        // Streaming 1,0,1,1 | 0,0,1,0 with out_ready high.
        out_ready = 1'b1;
        send_word(1'b1); send_word(1'b0); send_word(1'b1);
        check_eq("s_valid_early", 32'(out_valid), 32'd0);
        send_word(1'b1);
        check_eq("s_row0_valid", 32'(out_valid), 32'd1);
        check_eq("s_row0_data",  32'(out_data),  32'hD);
        send_word(1'b0);
        check_eq("s_row0_drained", 32'(out_valid), 32'd0);
        check_eq("s_rc1",          32'(row_count), 32'd1);
        send_word(1'b0); send_word(1'b1); send_word(1'b0);
        check_eq("s_row1_valid", 32'(out_valid), 32'd1);
        check_eq("s_row1_data",  32'(out_data),  32'h4);
        tick();
        check_eq("s_row1_drained", 32'(out_valid), 32'd0);
        check_eq("s_rc2",          32'(row_count), 32'd2);

        // Backpressure: 12 words offered, only 8 fit.
        do_reset();
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_data  = (k % 3 == 0);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check_eq("bp_accepted", 32'(accepted),  32'd8);
        check_eq("bp_in_ready", 32'(in_ready),  32'd0);
        check_eq("bp_wr_bank",  32'(wr_bank),   32'd0);
        check_eq("bp_rd_bank",  32'(rd_bank),   32'd0);
        check_eq("bp_valid",    32'(out_valid), 32'd1);
        out_ready = 1'b1;
        check_eq("bp_row0_data", 32'(out_data), 32'h9);
        tick();
        check_eq("bp_ready_back", 32'(in_ready), 32'd1);
        check_eq("bp_row1_data",  32'(out_data), 32'h4);
        tick();
        check_eq("bp_empty", 32'(out_valid), 32'd0);
        check_eq("bp_rc",    32'(row_count), 32'd2);
        out_ready = 1'b0;

        // Single-cycle out_ready pulse with both banks FULL and in_valid held.
        do_reset();
        send_word(1'b1); send_word(1'b1); send_word(1'b0); send_word(1'b0);
        send_word(1'b0); send_word(1'b1); send_word(1'b0); send_word(1'b1);
        in_valid  = 1'b1;
        in_data   = 1'b1;
        out_ready = 1'b1;
        check_eq("pl_ready_full", 32'(in_ready), 32'd0);
        check_eq("pl_row0_data",  32'(out_data), 32'h3);
        tick();
        out_ready = 1'b0;
        check_eq("pl_rc1",       32'(row_count), 32'd1);
        check_eq("pl_ready_up",  32'(in_ready),  32'd1);
        check_eq("pl_idx_hold",  32'(word_idx),  32'd0);
        tick();
        check_eq("pl_idx_acc",   32'(word_idx),  32'd1);
        check_eq("pl_rc_still",  32'(row_count), 32'd1);
        check_eq("pl_rd_bank",   32'(rd_bank),   32'd1);
        in_data   = 1'b0;
        out_ready = 1'b1;
        check_eq("pl_row1_data", 32'(out_data), 32'hA);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check_eq("pl_row2_valid", 32'(out_valid), 32'd1);
        check_eq("pl_row2_data",  32'(out_data),  32'h1);
        check_eq("pl_row2_bank",  32'(rd_bank),   32'd0);
        tick();
        check_eq("pl_rc3", 32'(row_count), 32'd3);
        out_ready = 1'b0;

        // Reset in the middle of a row.
        do_reset();
        send_word(1'b1); send_word(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mr_valid",   32'(out_valid), 32'd0);
        check_eq("mr_idx",     32'(word_idx),  32'd0);
        check_eq("mr_wr_bank", 32'(wr_bank),   32'd0);
        send_word(1'b0); send_word(1'b1); send_word(1'b1); send_word(1'b0);
        check_eq("mr_row_valid", 32'(out_valid), 32'd1);
        check_eq("mr_row_data",  32'(out_data),  32'h6);
        check_eq("mr_row_bank",  32'(rd_bank),   32'd0);

`ifdef AGG_ROW_FLUSH_EN
        // Flush of a 3-word partial row, then a no-op flush at slot 0.
        do_reset();
        send_word(1'b1); send_word(1'b1); send_word(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_valid",   32'(out_valid),   32'd1);
        check_eq("fl_data",    32'(out_data),    32'h7);
        check_eq("fl_partial", 32'(out_partial), 32'd1);
        check_eq("fl_idx",     32'(word_idx),    32'd0);
        check_eq("fl_wr_bank", 32'(wr_bank),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_noop_valid", 32'(out_valid), 32'd0);
        check_eq("fl_noop_bank",  32'(wr_bank),   32'd1);
`endif

        // Random valid/ready over 10000 words against a packing scoreboard.
        do_reset();
        exp_q.delete();
        acc  = '0;
        slot = 0;
        sent = 0;
        for (int cyc = 0; cyc < 60000 && (sent < 10000 || exp_q.size() > 0); cyc++) begin
            in_valid  = (sent < 10000) && 1'($urandom_range(0, 1));
            in_data   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            check_eq("rnd_in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
            check_eq("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_row = exp_q.pop_front();
                check_eq("rnd_row", 32'(out_data), 32'(exp_row));
            end
            if (in_valid && in_ready) begin
                acc[slot] = in_data;
                slot++;
                sent++;
                if (slot == 4) begin
                    exp_q.push_back(acc);
                    slot = 0;
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("rnd_sent",      32'(sent),         32'd10000);
        check_eq("rnd_left",      32'(exp_q.size()), 32'd0);
        check_eq("rnd_row_count", 32'(row_count),    32'd2500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
